// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   Program loader / self-test stimulus source for the instruction memory.
//   Symbolic instruction requests (operation select plus register, shift,
//   immediate and jump-target fields) arrive over a valid/ready handshake.
//   Each one is assembled into a 32-bit MIPS word and written to instruction
//   memory at sequentially incrementing word addresses.
//
// Optional feature macro: ENC_BRANCH_REL_EN
//   Defined   : BEQ/BNE in_imm is an absolute byte target; it is turned into a
//               PC-relative word offset, and a misaligned target sets err
//               (the word is still written).
//   Undefined : in_imm is copied verbatim into every I-type word.
//
// Parameters
//   BASE_ADDR : byte address of the first word; in_clr rewinds here
//   DEPTH     : words written before full asserts (1..65535)
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : request handshake
//   in_op             : operation select (0..16 legal, 17..31 illegal)
//   in_rs/rt/rd/shamt : register and shift fields
//   in_imm, in_target : I-type immediate, J-type target
//   in_clr            : rewind write address and zero the word count (IDLE only)
//   im_we/addr/wdata  : instruction memory write port, held until im_ack
//   im_ack            : memory accepted the write
//   count, full, err  : words written, count==DEPTH, sticky error flag
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  input  logic        in_clr,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  input  logic        im_ack,
  output logic [15:0] count,
  output logic        full,
  output logic        err
);

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] count_q, count_d;
  logic        full_q, full_d;
  logic        err_q, err_d;

  logic        accept_s;
  logic [15:0] imm_eff_s;
  logic        br_mis_s;
  logic [32:0] enc_s;

  // Returns {legal, word}. imm is already adjusted for branch mode.
  function automatic logic [32:0] encode(
    input logic [4:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic        legal;
    logic        rtype;
    logic        shift;
    logic        rs_zero;
    logic [5:0]  funct;
    logic [5:0]  opc;
    logic [31:0] word;
    legal   = 1'b1;
    rtype   = 1'b0;
    shift   = 1'b0;
    rs_zero = 1'b0;
    funct   = 6'b000000;
    opc     = 6'b000000;
    case (op)
      5'd0:  begin rtype = 1'b1; funct = 6'b100001; end // ADDU
      5'd1:  begin rtype = 1'b1; funct = 6'b100000; end // ADD
      5'd2:  begin rtype = 1'b1; funct = 6'b100011; end // SUBU
      5'd3:  begin rtype = 1'b1; funct = 6'b100010; end // SUB
      5'd4:  begin rtype = 1'b1; funct = 6'b101010; end // SLT
      5'd5:  begin rtype = 1'b1; shift = 1'b1; funct = 6'b000000; end // SLL
      5'd6:  begin rtype = 1'b1; shift = 1'b1; funct = 6'b000010; end // SRL
      5'd7:  begin rtype = 1'b1; shift = 1'b1; funct = 6'b000011; end // SRA
      5'd8:  begin rtype = 1'b1; funct = 6'b100100; end // AND
      5'd9:  opc = 6'b001101;                           // ORI
      5'd10: opc = 6'b101011;                           // SW
      5'd11: opc = 6'b100011;                           // LW
      5'd12: opc = 6'b000100;                           // BEQ
      5'd13: opc = 6'b000101;                           // BNE
      5'd14: begin opc = 6'b001111; rs_zero = 1'b1; end // LUI
      5'd15: opc = 6'b001010;                           // SLTI
      5'd16: opc = 6'b000010;                           // J
      default: legal = 1'b0;
    endcase
    if (op == 5'd16) begin
      word = {opc, target};
    end else if (rtype) begin
      // Shifts take their source from rt, so rs is zeroed; others carry no shamt.
      word = {6'b000000, (shift ? 5'd0 : rs), rt, rd, (shift ? shamt : 5'd0), funct};
    end else begin
      word = {opc, (rs_zero ? 5'd0 : rs), rt, imm};
    end
    return {legal, word};
  endfunction

  // Branch immediate adjustment (relative mode) or pass-through.
`ifdef ENC_BRANCH_REL_EN
  logic [15:0] br_diff_s;
  always_comb begin
    // Offset is measured from the word after the branch itself.
    br_diff_s = in_imm - (addr_q[15:0] + 16'd4);
    if ((in_op == 5'd12) || (in_op == 5'd13)) begin
      imm_eff_s = {{2{br_diff_s[15]}}, br_diff_s[15:2]};
      br_mis_s  = (br_diff_s[1:0] != 2'b00);
    end else begin
      imm_eff_s = in_imm;
      br_mis_s  = 1'b0;
    end
  end
`else
  // Immediate passes through unchanged; no misalignment detection.
  always_comb begin
    imm_eff_s = in_imm;
    br_mis_s  = 1'b0;
  end
`endif

  // Instruction word assembly for the request currently presented.
  always_comb begin
    enc_s = encode(in_op, in_rs, in_rt, in_rd, in_shamt, imm_eff_s, in_target);
  end

  // Output decode: handshake ready and write strobe from registered state.
  always_comb begin
    in_ready = (state_q == S_IDLE) && !full_q && !in_clr;
    im_we    = (state_q == S_WRITE);
    accept_s = in_valid && in_ready;
  end

  assign im_addr  = addr_q;
  assign im_wdata = wdata_q;
  assign count    = count_q;
  assign full     = full_q;
  assign err      = err_q;

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    full_d  = full_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_clr) begin
          addr_d  = BASE_ADDR;
          count_d = 16'd0;
          full_d  = 1'b0;
        end else if (accept_s) begin
          if (enc_s[32]) begin
            wdata_d = enc_s[31:0];
            state_d = S_WRITE;
            if (br_mis_s) begin
              err_d = 1'b1;
            end else begin
              err_d = err_q;
            end
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (im_ack) begin
          // Address wraps modulo 2^32 silently.
          addr_d  = addr_q + 32'd4;
          count_d = count_q + 16'd1;
          full_d  = ((count_q + 16'd1) == DEPTH_W);
          state_d = S_IDLE;
        end else begin
          state_d = S_WRITE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= BASE_ADDR;
      wdata_q <= 32'd0;
      count_q <= 16'd0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

endmodule
